reduce_tree: RTL and testbench



---
 rtl/reduce_tree_pkg.sv | 72 +++++++
 rtl/reduce_stage.sv | 51 +++++
 rtl/reduce_tree.sv | 146 ++++++++++++++
 tb/tb_reduce_tree.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reduce_tree_pkg.sv
// Shared types and arithmetic helpers for the reduce_tree pipeline.
// Values are handled internally as sign-extended 64-bit words and truncated by the caller.
package reduce_tree_pkg;

  localparam int MAX_OW = 64;

  typedef enum logic [1:0] {
    MODE_SUM = 2'b00,
    MODE_MAX = 2'b01,
    MODE_MIN = 2'b10
  } mode_e;

  typedef struct packed {
    logic  any;
    mode_e mode;
    logic  start;
    logic  last;
  } side_t;

  typedef logic signed [MAX_OW-1:0] wide_t;

  // Encoding 11 folds onto sum.
  function automatic mode_e decode_mode(logic [1:0] m);
    mode_e r;
    case (m)
      2'b01:   r = MODE_MAX;
      2'b10:   r = MODE_MIN;
      default: r = MODE_SUM;
    endcase
    return r;
  endfunction

  function automatic wide_t identity(mode_e m, int ow);
    wide_t neg;
    wide_t r;
    neg = '1;
    neg = neg << (ow - 1);
    case (m)
      MODE_MAX: r = neg;
      MODE_MIN: r = ~neg;
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic wide_t combine(mode_e m, wide_t a, wide_t b);
    wide_t r;
    case (m)
      MODE_MAX: r = (a > b) ? a : b;
      MODE_MIN: r = (a < b) ? a : b;
      default:  r = a + b;
    endcase
    return r;
  endfunction

  // Element count after k combining layers starting from n lanes.
  function automatic int elems(int n, int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

  // Element offset of layer k inside the concatenated pipeline bus.
  function automatic int seg_offset(int n, int k);
    int s;
    s = 0;
    for (int i = 0; i < k; i++) s += elems(n, i);
    return s;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One combining layer: M elements in, ceil(M/2) out, registered with valid/ready.
// valid/ready: a beat moves when valid && ready; in_ready = !out_valid || out_ready.
module reduce_stage
  import reduce_tree_pkg::*;
#(
  parameter  int M  = 4,
  parameter  int OW = 24,
  localparam int MO = (M + 1) / 2
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [M*OW-1:0] in_data,
  input  side_t           in_side,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [MO*OW-1:0] out_data,
  output side_t           out_side,
  output logic            out_valid,
  input  logic            out_ready
);

  logic [MO*OW-1:0] folded;

  for (genvar j = 0; j < M / 2; j++) begin : g_pair
    assign folded[j*OW +: OW] = OW'(combine(in_side.mode,
                                            wide_t'($signed(in_data[2*j*OW +: OW])),
                                            wide_t'($signed(in_data[(2*j+1)*OW +: OW]))));
  end

  // Odd count: the leftover element is equivalent to pairing it with the identity.
  if (M % 2 == 1) begin : g_odd
    assign folded[(MO-1)*OW +: OW] = in_data[(M-1)*OW +: OW];
  end

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_side  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= folded;
        out_side <= in_side;
      end
    end
  end

endmodule

// File: rtl/reduce_tree.sv
// Pipelined signed sum/max/min reduction of N lanes with per-stage backpressure.
// Optional REDUCE_TREE_ACC_EN adds a per-packet accumulator after the final layer.
module reduce_tree
  import reduce_tree_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int OW = 24
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [N*W-1:0] idata,
  input  logic [N-1:0]  lane_mask,
  input  logic [1:0]    mode,
  input  logic          ivalid,
  output logic          iready,
  input  logic          istart,
  input  logic          ilast,
  output logic [OW-1:0] odata,
  output logic          ovalid,
  input  logic          oready,
  output logic          ostart,
  output logic          olast
);

  localparam int L     = $clog2(N);
  localparam int TOTAL = OW * seg_offset(N, L + 1);

  if (OW < W + $clog2(N) || OW > MAX_OW) begin : g_bad_ow
    $error("reduce_tree: OW must be in [W+clog2(N), 64]");
  end

  // Every layer's registered elements live in one bus, layer k at seg_offset(N,k).
  logic [TOTAL-1:0] bus;
  logic             valid [0:L];
  side_t            side  [0:L];
  logic             ready [0:L+1];

  mode_e            in_mode;
  logic [N*OW-1:0]  lanes_ext;
  side_t            in_side;
  logic [N*OW-1:0]  s0_data;
  side_t            s0_side;
  logic             s0_valid;
  logic [OW-1:0]    tree_res;

  assign in_mode = decode_mode(mode);
  assign in_side = '{any: |lane_mask, mode: in_mode, start: istart, last: ilast};

  always_comb begin
    lanes_ext = '0;
    for (int i = 0; i < N; i++) begin
      if (lane_mask[N-1-i]) lanes_ext[i*OW +: OW] = OW'($signed(idata[W*(N-i)-1 -: W]));
      else                  lanes_ext[i*OW +: OW] = OW'(identity(in_mode, OW));
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_side  <= '0;
    end else if (ready[0]) begin
      s0_valid <= ivalid;
      if (ivalid) begin
        s0_data <= lanes_ext;
        s0_side <= in_side;
      end
    end
  end

  assign bus[N*OW-1:0] = s0_data;
  assign valid[0]      = s0_valid;
  assign side[0]       = s0_side;
  assign ready[0]      = !s0_valid || ready[1];
  assign iready        = ready[0];

  for (genvar k = 0; k < L; k++) begin : g_layer
    localparam int MI = elems(N, k);
    localparam int MO = elems(N, k + 1);
    localparam int OI = OW * seg_offset(N, k);
    localparam int OO = OW * seg_offset(N, k + 1);

    reduce_stage #(.M(MI), .OW(OW)) u_stage (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_data   (bus[OI +: MI*OW]),
      .in_side   (side[k]),
      .in_valid  (valid[k]),
      .in_ready  (ready[k+1]),
      .out_data  (bus[OO +: MO*OW]),
      .out_side  (side[k+1]),
      .out_valid (valid[k+1]),
      .out_ready (ready[k+2])
    );
  end

  // A beat with no enabled lane reports 0 regardless of mode.
  assign tree_res = side[L].any ? bus[TOTAL-1 -: OW] : '0;

`ifdef REDUCE_TREE_ACC_EN
  logic [OW-1:0] acc;
  logic [OW-1:0] res_q;
  logic [OW-1:0] fold;
  logic          ov_q;
  logic          take;

  assign ready[L+1] = !ov_q || oready;
  assign take       = valid[L] && ready[L+1];

  always_comb begin
    fold = tree_res;
    if (!side[L].start)
      fold = OW'(combine(side[L].mode, wide_t'($signed(acc)), wide_t'($signed(tree_res))));
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      acc   <= '0;
      res_q <= '0;
      ov_q  <= 1'b0;
    end else begin
      if (ov_q && oready) ov_q <= 1'b0;
      if (take) begin
        acc <= fold;
        if (side[L].last) begin
          res_q <= fold;
          ov_q  <= 1'b1;
        end
      end
    end
  end

  assign odata  = res_q;
  assign ovalid = ov_q;
  assign ostart = ov_q;
  assign olast  = ov_q;
`else
  assign ready[L+1] = oready;
  assign odata      = tree_res;
  assign ovalid     = valid[L];
  assign ostart     = side[L].start;
  assign olast      = side[L].last;
`endif

endmodule

// File: tb/tb_reduce_tree.sv
// Directed bench for reduce_tree: an N=4 instance plus an N=5 instance for the odd-width case.
module tb_reduce_tree;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int OW = 24;
  localparam int N5 = 5;

  // clock / reset
  logic aclk = 1'b0;
  always #5 aclk = ~aclk;
  logic aresetn;

  logic [N*W-1:0]  idata;
  logic [N-1:0]    lane_mask;
  logic [1:0]      mode;
  logic            ivalid, iready, istart, ilast;
  logic [OW-1:0]   odata;
  logic            ovalid, oready, ostart, olast;

  logic [N5*W-1:0] idata_5;
  logic [N5-1:0]   lane_mask_5;
  logic [1:0]      mode_5;
  logic            ivalid_5, iready_5, istart_5, ilast_5;
  logic [OW-1:0]   odata_5;
  logic            ovalid_5, oready_5, ostart_5, olast_5;

  int n_checks = 0;
  int n_fail   = 0;
  logic [OW-1:0] exp_q[$];

  reduce_tree #(.N(N), .W(W), .OW(OW)) dut (
    .aclk(aclk), .aresetn(aresetn), .idata(idata), .lane_mask(lane_mask), .mode(mode),
    .ivalid(ivalid), .iready(iready), .istart(istart), .ilast(ilast),
    .odata(odata), .ovalid(ovalid), .oready(oready), .ostart(ostart), .olast(olast)
  );

  reduce_tree #(.N(N5), .W(W), .OW(OW)) dut5 (
    .aclk(aclk), .aresetn(aresetn), .idata(idata_5), .lane_mask(lane_mask_5), .mode(mode_5),
    .ivalid(ivalid_5), .iready(iready_5), .istart(istart_5), .ilast(ilast_5),
    .odata(odata_5), .ovalid(ovalid_5), .oready(oready_5), .ostart(ostart_5), .olast(olast_5)
  );

  function automatic logic [N*W-1:0] pack4(int a, int b, int c, int d);
    return {a[15:0], b[15:0], c[15:0], d[15:0]};
  endfunction

  // driver: present one beat and hold it until accepted (called at posedge+1)
  task automatic send(input logic [N*W-1:0] d, input logic [N-1:0] m, input logic [1:0] md,
                      input logic s, input logic l, output bit ok);
    idata = d; lane_mask = m; mode = md; istart = s; ilast = l; ivalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge aclk);
      ok = iready;
      @(posedge aclk); #1;
    end
    ivalid = 1'b0;
    idata  = $urandom;
    if (!ok) begin
      n_checks++; n_fail++;
      $display("FAIL send_timeout: iready low for 50 cycles, required 1");
    end
  endtask

  // driver: send a beat with oready=1, then report the output and its latency in cycles
  task automatic drive_and_wait(input logic [N*W-1:0] d, input logic [N-1:0] m,
                                input logic [1:0] md, input logic s, input logic l,
                                output logic [OW-1:0] od, output logic os, output logic ol,
                                output int lat);
    bit ok;
    oready = 1'b1;
    send(d, m, md, s, l, ok);
    lat = -1; od = 'x; os = 1'bx; ol = 1'bx;
    if (ok) begin
      for (int t = 1; t <= 20; t++) begin
        @(negedge aclk);
        if (ovalid) begin
          lat = t; od = odata; os = ostart; ol = olast;
          break;
        end
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid: got %b expected 0", ovalid); end
    n_checks++; if (odata !== '0) begin n_fail++; $display("FAIL reset_odata: got %h expected 0", odata); end
    n_checks++; if (ostart !== 1'b0) begin n_fail++; $display("FAIL reset_ostart: got %b expected 0", ostart); end
    n_checks++; if (olast !== 1'b0) begin n_fail++; $display("FAIL reset_olast: got %b expected 0", olast); end
    n_checks++; if (ovalid_5 !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid5: got %b expected 0", ovalid_5); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    @(negedge aclk);
    n_checks++; if (iready !== 1'b1) begin n_fail++; $display("FAIL reset_iready: got %b expected 1", iready); end
    @(posedge aclk); #1;
  endtask

  task automatic test_sum;
    logic [OW-1:0] od; logic os, ol; int lat;
    drive_and_wait(pack4(1, 2, 3, 4), 4'b1111, 2'b00, 1'b1, 1'b0, od, os, ol, lat);
    n_checks++; if (od !== 24'd10) begin n_fail++; $display("FAIL sum_data: got %h expected %h", od, 24'd10); end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sum_latency: got %0d expected 3", lat); end
    n_checks++; if (os !== 1'b1) begin n_fail++; $display("FAIL sum_ostart: got %b expected 1", os); end
    n_checks++; if (ol !== 1'b0) begin n_fail++; $display("FAIL sum_olast: got %b expected 0", ol); end
    drive_and_wait(pack4(100, -50, 7, 0), 4'b1111, 2'b00, 1'b0, 1'b1, od, os, ol, lat);
    n_checks++; if (od !== 24'd57) begin n_fail++; $display("FAIL sum2_data: got %h expected %h", od, 24'd57); end
    n_checks++; if (os !== 1'b0 || ol !== 1'b1) begin n_fail++; $display("FAIL sum2_side: got start=%b last=%b expected start=0 last=1", os, ol); end
  endtask

  task automatic test_mask_minmax;
    logic [OW-1:0] od; logic os, ol; int lat;
    drive_and_wait(pack4(-5, 7, -32768, 6), 4'b1011, 2'b01, 1'b0, 1'b0, od, os, ol, lat);
    n_checks++; if (od !== 24'd6) begin n_fail++; $display("FAIL max_masked: got %h expected %h", od, 24'd6); end
    drive_and_wait(pack4(-5, 7, -32768, 6), 4'b1011, 2'b10, 1'b0, 1'b0, od, os, ol, lat);
    n_checks++; if (od !== 24'hFF8000) begin n_fail++; $display("FAIL min_masked: got %h expected %h", od, 24'hFF8000); end
    // mode 11 behaves as sum: -5 + -32768 + 6
    drive_and_wait(pack4(-5, 7, -32768, 6), 4'b1011, 2'b11, 1'b0, 1'b0, od, os, ol, lat);
    n_checks++; if (od !== 24'hFF8001) begin n_fail++; $display("FAIL mode3_sum: got %h expected %h", od, 24'hFF8001); end
  endtask

  task automatic test_all_masked;
    logic [OW-1:0] od; logic os, ol; int lat;
    for (int md = 0; md < 3; md++) begin
      drive_and_wait(pack4(-9, 1234, 77, -1), 4'b0000, 2'(md), 1'b0, 1'b0, od, os, ol, lat);
      n_checks++; if (od !== '0) begin n_fail++; $display("FAIL all_masked_mode%0d: got %h expected 0", md, od); end
    end
  endtask

  task automatic test_wide;
    bit ok; int lat; logic [OW-1:0] od;
    idata_5 = {5{16'h7FFF}}; lane_mask_5 = '1; mode_5 = 2'b00;
    istart_5 = 1'b1; ilast_5 = 1'b1; ivalid_5 = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge aclk); ok = iready_5; @(posedge aclk); #1;
    end
    ivalid_5 = 1'b0;
    lat = -1; od = 'x;
    for (int t = 1; t <= 20 && ok; t++) begin
      @(negedge aclk);
      if (ovalid_5) begin lat = t; od = odata_5; break; end
    end
    @(posedge aclk); #1;
    n_checks++; if (od !== 24'd163835) begin n_fail++; $display("FAIL wide_sum: got %h expected %h", od, 24'd163835); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL wide_latency: got %0d expected 4", lat); end
  endtask

  task automatic test_reset_flight;
    int seen;
    oready = 1'b0;
    for (int b = 0; b < 3; b++) begin
      idata = pack4(b + 1, 1, 1, 1); lane_mask = '1; mode = 2'b00;
      istart = 1'b0; ilast = 1'b0; ivalid = 1'b1;
      @(negedge aclk);
      n_checks++; if (iready !== 1'b1) begin n_fail++; $display("FAIL flight_iready%0d: got %b expected 1", b, iready); end
      @(posedge aclk); #1;
    end
    ivalid = 1'b0;
    @(negedge aclk);
    n_checks++; if (ovalid !== 1'b1) begin n_fail++; $display("FAIL flight_head: got ovalid=%b expected 1", ovalid); end
    @(posedge aclk); #1;
    aresetn = 1'b0; oready = 1'b1;
    @(posedge aclk); #1;
    @(negedge aclk);
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL flight_in_reset: got ovalid=%b expected 0", ovalid); end
    @(posedge aclk); #1;
    aresetn = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge aclk);
      if (ovalid) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL flight_after_release: got %0d output beats expected 0", seen); end
    @(posedge aclk); #1;
  endtask

  task automatic test_back_to_back;
    int got; logic [OW-1:0] prev_d, e; logic prev_stall; bit mon_done, ok;
    got = 0; prev_stall = 1'b0; prev_d = '0; mon_done = 1'b0;
    oready = 1'b0;
    fork
      begin
        for (int v = 1; v <= 8; v++) begin
          int gap;
          gap = $urandom_range(0, 2);
          repeat (gap) begin idata = $urandom; @(posedge aclk); #1; end
          exp_q.push_back((v % 2 == 1) ? OW'(5 * v) : OW'(3 * v));
          send(pack4(v, 2 * v, -v, 3 * v), 4'b1111, (v % 2 == 1) ? 2'b00 : 2'b01,
               v == 1, v == 8, ok);
        end
      end
      begin
        while (!mon_done) begin oready = ~oready; @(posedge aclk); #1; end
        oready = 1'b1;
      end
      begin
        for (int t = 0; t < 300 && got < 8; t++) begin
          @(negedge aclk);
          if (prev_stall) begin
            n_checks++;
            if (ovalid !== 1'b1 || odata !== prev_d) begin
              n_fail++;
              $display("FAIL b2b_stall_hold: got valid=%b data=%h expected valid=1 data=%h", ovalid, odata, prev_d);
            end
          end
          if (ovalid && oready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
              n_fail++; $display("FAIL b2b_extra: got %h expected no beat", odata);
            end else begin
              e = exp_q.pop_front();
              if (odata !== e) begin n_fail++; $display("FAIL b2b_data: got %h expected %h", odata, e); end
            end
            got++;
          end
          prev_stall = ovalid && !oready;
          prev_d = odata;
        end
        mon_done = 1'b1;
      end
    join
    n_checks++; if (got !== 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", got); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d pending expected 0", exp_q.size()); end
    exp_q.delete();
  endtask

  // collector: count output beats over a window and keep the first one
  task automatic collect(input int cycles, output int cnt, output logic [OW-1:0] d,
                         output logic s, output logic l);
    cnt = 0; d = 'x; s = 1'bx; l = 1'bx;
    repeat (cycles) begin
      @(negedge aclk);
      if (ovalid && oready) begin
        if (cnt == 0) begin d = odata; s = ostart; l = olast; end
        cnt++;
      end
    end
  endtask

  task automatic test_acc;
    int cnt; logic [OW-1:0] d; logic s, l; bit ok;
    oready = 1'b1;
    fork
      begin
        send(pack4(10, 20, 30, 40), 4'b1111, 2'b00, 1'b1, 1'b0, ok);
        send(pack4(50, 25, 25, 0), 4'b1111, 2'b00, 1'b0, 1'b0, ok);
        send(pack4(-100, 150, 40, 10), 4'b1111, 2'b00, 1'b0, 1'b1, ok);
      end
      collect(20, cnt, d, s, l);
    join
    @(posedge aclk); #1;
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL acc_count: got %0d expected 1", cnt); end
    n_checks++; if (d !== 24'd300) begin n_fail++; $display("FAIL acc_sum: got %h expected %h", d, 24'd300); end
    n_checks++; if (s !== 1'b1 || l !== 1'b1) begin n_fail++; $display("FAIL acc_side: got start=%b last=%b expected 1 1", s, l); end
    fork
      send(pack4(1, 2, 3, 4), 4'b1111, 2'b00, 1'b1, 1'b1, ok);
      collect(12, cnt, d, s, l);
    join
    @(posedge aclk); #1;
    n_checks++; if (cnt !== 1) begin n_fail++; $display("FAIL acc_single_count: got %0d expected 1", cnt); end
    n_checks++; if (d !== 24'd10) begin n_fail++; $display("FAIL acc_single: got %h expected %h", d, 24'd10); end
    fork
      begin
        send(pack4(-5, 7, 3, 1), 4'b1111, 2'b01, 1'b1, 1'b0, ok);
        send(pack4(2, 9, -4, 0), 4'b1111, 2'b01, 1'b0, 1'b1, ok);
      end
      collect(16, cnt, d, s, l);
    join
    @(posedge aclk); #1;
    n_checks++; if (d !== 24'd9) begin n_fail++; $display("FAIL acc_max: got %h expected %h", d, 24'd9); end
  endtask

  initial begin
    aresetn = 1'b0; idata = '0; lane_mask = '0; mode = 2'b00;
    ivalid = 1'b0; istart = 1'b0; ilast = 1'b0; oready = 1'b1;
    idata_5 = '0; lane_mask_5 = '0; mode_5 = 2'b00;
    ivalid_5 = 1'b0; istart_5 = 1'b0; ilast_5 = 1'b0; oready_5 = 1'b1;
    @(posedge aclk); #1;
    test_reset;
`ifdef REDUCE_TREE_ACC_EN
    test_acc;
`else
    test_sum;
    test_mask_minmax;
    test_all_masked;
    test_wide;
    test_reset_flight;
    test_back_to_back;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
